// File: rtl/mop_issue_scheduler.sv
// Head-of-decode-queue issue controller: scoreboard hazard check, ALU/MEM routing,
// and taken-branch redirect sequencing against outstanding I-fetch reads.
module mop_issue_scheduler #(
    parameter int REG_CNT  = 32,
    parameter int REG_ID_W = 5,
    parameter int ADDR_W   = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mop_valid,
    input  logic [1:0]          mop_class,
    input  logic [REG_ID_W-1:0] mop_src0_id,
    input  logic [REG_ID_W-1:0] mop_src1_id,
    input  logic [REG_ID_W-1:0] mop_dst_id,
    input  logic                br_taken,
    input  logic [ADDR_W-1:0]   br_target,
    output logic                mop_issue,
    output logic                alu_issue,
    input  logic                alu_busy,
    output logic                mem_issue,
    input  logic                mem_busy,
    input  logic                wb_alu_valid,
    input  logic [REG_ID_W-1:0] wb_alu_dst,
    input  logic                wb_mem_valid,
    input  logic [REG_ID_W-1:0] wb_mem_dst,
    input  logic                fetch_pending,
    input  logic                fetch_resp,
    output logic                redirect,
    output logic [ADDR_W-1:0]   redirect_pc,
    output logic [REG_CNT-1:0]  sb_busy,
    output logic [31:0]         issued_cnt,
    output logic [31:0]         stall_cnt
);

    localparam logic [1:0] CLS_ALU = 2'd0;
    localparam logic [1:0] CLS_MEM = 2'd1;
    localparam logic [1:0] CLS_BR  = 2'd2;

    typedef enum logic [1:0] {RUN, BR_WAIT, REDIRECT, FLUSH} state_t;

    state_t               state, state_nxt;
    logic                 mem_inflight;
    logic                 consume;
    logic                 br_take;
    logic                 hazard;
    logic                 mem_free;
    logic [REG_CNT-1:0]   sb_clr, sb_eff, sb_set, sb_nxt;

    // Ids at or above REG_CNT decode to an empty mask, so they are never tracked.
    function automatic logic [REG_CNT-1:0] reg_mask(input logic [REG_ID_W-1:0] id);
        logic [REG_CNT-1:0] m;
        m = '0;
        for (int i = 0; i < REG_CNT; i++)
            m[i] = (32'(id) == i[31:0]);
        return m;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Same-cycle writebacks are bypassed so a dependent op can issue in the wb cycle.
    always_comb begin
        sb_clr   = (wb_alu_valid ? reg_mask(wb_alu_dst) : '0)
                 | (wb_mem_valid ? reg_mask(wb_mem_dst) : '0);
        sb_eff   = sb_busy & ~sb_clr;
        hazard   = |(sb_eff & (reg_mask(mop_src0_id) | reg_mask(mop_src1_id)
                               | reg_mask(mop_dst_id)));
        mem_free = !mem_inflight || wb_mem_valid;
    end

    always_comb begin
        state_nxt = state;
        alu_issue = 1'b0;
        mem_issue = 1'b0;
        consume   = 1'b0;
        br_take   = 1'b0;
        case (state)
            RUN: begin
                if (reset && mop_valid && !hazard) begin
                    case (mop_class)
                        CLS_ALU: alu_issue = !alu_busy;
                        CLS_MEM: mem_issue = !mem_busy && mem_free;
                        CLS_BR: begin
                            consume = 1'b1;
                            if (br_taken) begin
                                br_take   = 1'b1;
                                state_nxt = BR_WAIT;
                            end
                        end
                        default: consume = 1'b1;
                    endcase
                end
            end
            BR_WAIT:  if (!fetch_pending || fetch_resp) state_nxt = REDIRECT;
            REDIRECT: state_nxt = FLUSH;
            FLUSH:    state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
        mop_issue = alu_issue | mem_issue | consume;
        sb_set    = (alu_issue || mem_issue) ? reg_mask(mop_dst_id) : '0;
        sb_nxt    = sb_eff | sb_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            sb_busy      <= '0;
            mem_inflight <= 1'b0;
            redirect     <= 1'b0;
            redirect_pc  <= '0;
            issued_cnt   <= '0;
            stall_cnt    <= '0;
        end else begin
            state        <= state_nxt;
            sb_busy      <= sb_nxt;
            mem_inflight <= mem_issue || (mem_inflight && !wb_mem_valid);
            redirect     <= (state_nxt == REDIRECT);
            if (br_take)
                redirect_pc <= br_target;
            if (mop_issue)
                issued_cnt <= sat_inc(issued_cnt);
            if (state == RUN && mop_valid && !mop_issue)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule
